// File: rtl/bullet_renderer.sv
// ---------------------------------------------------------------------------
// bullet_renderer
//
// Purpose:
//   Takes the bullet generator's packed coordinate bus and draws live bullets
//   into the VGA frame buffer. Any bullet that moved or retired has its
//   previous square erased first. One render pass runs per start pulse
//   (frame tick). Each pass walks every slot in turn and emits at most one
//   pixel write per cycle.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   start           begin a render pass (sampled only while idle)
//   bullets_moving  per-slot "in flight" flags
//   plot_bullet     per-slot "draw me" flags
//   bullet_x_coord  packed x coordinates, slot i at [i*X_W +: X_W]
//   bullet_y_coord  packed y coordinates, slot i at [i*Y_W +: Y_W]
//   vga_x/vga_y     registered pixel coordinate
//   vga_colour      registered pixel colour
//   vga_plot        registered write strobe, one pixel per high cycle
//   busy            high while a pass is in progress
//   done            one-cycle pulse when a pass finishes
// ---------------------------------------------------------------------------
module bullet_renderer #(
    parameter int       NUM_SLOTS = 8,
    parameter int       X_W       = 8,
    parameter int       Y_W       = 7,
    parameter int       SIZE      = 2,
    parameter int       X_MAX     = 159,
    parameter int       Y_MAX     = 119,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_SLOTS-1:0]     bullets_moving,
    input  logic [NUM_SLOTS-1:0]     plot_bullet,
    input  logic [NUM_SLOTS*X_W-1:0] bullet_x_coord,
    input  logic [NUM_SLOTS*Y_W-1:0] bullet_y_coord,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    // SIZE is at most 4, so the pixel offsets within a square fit in 2 bits.
    localparam int CW = 2;

    localparam logic [CW-1:0] LAST_D = CW'(SIZE - 1);
    localparam logic [SW-1:0] LAST_S = SW'(NUM_SLOTS - 1);
    localparam logic [X_W:0]  X_LIM  = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0]  Y_LIM  = (Y_W + 1)'(Y_MAX);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_ERASE = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic [2:0]           state_r;
    logic [SW-1:0]        s_r;
    logic [CW-1:0]        dx_r;
    logic [CW-1:0]        dy_r;

    // Input snapshot taken when a pass starts.
    logic [NUM_SLOTS-1:0] snap_moving_r;
    logic [NUM_SLOTS-1:0] snap_plot_r;
    logic [X_W-1:0]       snap_x_r [NUM_SLOTS];
    logic [Y_W-1:0]       snap_y_r [NUM_SLOTS];

    // Where each slot was last drawn on screen.
    logic [X_W-1:0]       last_x_r [NUM_SLOTS];
    logic [Y_W-1:0]       last_y_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] last_valid_r;

    logic [X_W-1:0]       vga_x_r;
    logic [Y_W-1:0]       vga_y_r;
    logic [2:0]           vga_colour_r;
    logic                 vga_plot_r;
    logic                 busy_r;
    logic                 done_r;

    logic [X_W-1:0]       cur_x_s;
    logic [Y_W-1:0]       cur_y_s;
    logic [X_W-1:0]       base_x_s;
    logic [Y_W-1:0]       base_y_s;
    logic [X_W:0]         pix_x_s;
    logic [Y_W:0]         pix_y_s;
    logic                 draw_req_s;
    logic                 same_pos_s;
    logic                 clipped_s;
    logic                 last_pix_s;
    logic                 last_slot_s;

    // Per-slot decode for the current slot plus the pixel address of the
    // current ERASE/DRAW cycle.
    always_comb begin
        cur_x_s     = snap_x_r[s_r];
        cur_y_s     = snap_y_r[s_r];
        draw_req_s  = snap_plot_r[s_r] & snap_moving_r[s_r];
        same_pos_s  = (last_x_r[s_r] == cur_x_s) && (last_y_r[s_r] == cur_y_s);
        if (state_r == ST_ERASE) begin
            base_x_s = last_x_r[s_r];
            base_y_s = last_y_r[s_r];
        end else begin
            base_x_s = cur_x_s;
            base_y_s = cur_y_s;
        end
        // One extra bit so a square near the right/bottom edge never wraps
        // back to column/row 0; it clips instead.
        pix_x_s     = {1'b0, base_x_s} + {{(X_W + 1 - CW){1'b0}}, dx_r};
        pix_y_s     = {1'b0, base_y_s} + {{(Y_W + 1 - CW){1'b0}}, dy_r};
        clipped_s   = (pix_x_s > X_LIM) || (pix_y_s > Y_LIM);
        last_pix_s  = (dx_r == LAST_D) && (dy_r == LAST_D);
        last_slot_s = (s_r == LAST_S);
    end

    // Render FSM, snapshot, per-slot history and registered VGA outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            s_r          <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            last_valid_r <= '0;
            vga_x_r      <= '0;
            vga_y_r      <= '0;
            vga_colour_r <= 3'b000;
            vga_plot_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            vga_plot_r <= 1'b0;
            done_r     <= 1'b0;
            // Lagging state by one cycle gives busy exactly one cycle per
            // SCAN/ERASE/DRAW cycle, ending as done rises.
            busy_r     <= (state_r == ST_SCAN) || (state_r == ST_ERASE) ||
                          (state_r == ST_DRAW);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        snap_moving_r <= bullets_moving;
                        snap_plot_r   <= plot_bullet;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            snap_x_r[i] <= bullet_x_coord[i*X_W +: X_W];
                            snap_y_r[i] <= bullet_y_coord[i*Y_W +: Y_W];
                        end
                        s_r     <= '0;
                        state_r <= ST_SCAN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    dx_r <= '0;
                    dy_r <= '0;
                    if (last_valid_r[s_r] && draw_req_s && same_pos_s) begin
                        if (last_slot_s) begin
                            state_r <= ST_FIN;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end else if (last_valid_r[s_r]) begin
                        state_r <= ST_ERASE;
                    end else if (draw_req_s) begin
                        state_r <= ST_DRAW;
                    end else if (last_slot_s) begin
                        state_r <= ST_FIN;
                    end else begin
                        s_r <= s_r + SW'(1);
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    // Clipped pixels still use their cycle, but the outputs hold.
                    if (!clipped_s) begin
                        vga_plot_r   <= 1'b1;
                        vga_x_r      <= pix_x_s[X_W-1:0];
                        vga_y_r      <= pix_y_s[Y_W-1:0];
                        vga_colour_r <= (state_r == ST_ERASE) ? BG_COLOUR : FG_COLOUR;
                    end else begin
                        vga_plot_r   <= 1'b0;
                    end
                    if (last_pix_s) begin
                        dx_r <= '0;
                        dy_r <= '0;
                        if (state_r == ST_ERASE) begin
                            last_valid_r[s_r] <= 1'b0;
                        end else begin
                            last_x_r[s_r]     <= cur_x_s;
                            last_y_r[s_r]     <= cur_y_s;
                            last_valid_r[s_r] <= 1'b1;
                        end
                        if ((state_r == ST_ERASE) && draw_req_s) begin
                            state_r <= ST_DRAW;
                        end else if (last_slot_s) begin
                            state_r <= ST_FIN;
                        end else begin
                            s_r     <= s_r + SW'(1);
                            state_r <= ST_SCAN;
                        end
                    end else if (dx_r == LAST_D) begin
                        dx_r <= '0;
                        dy_r <= dy_r + CW'(1);
                    end else begin
                        dx_r <= dx_r + CW'(1);
                    end
                end
                ST_FIN: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign vga_plot   = vga_plot_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
